hazard_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage core.
- Drives stall/flush into pc_reg, if_id_reg, id_ex_reg and ex_mem_reg.
- Sequences load-use bubbles, taken-branch flushes, multi-cycle MDU occupancy of EX, and data-memory wait states.
- Holds a small FSM plus MDU countdown and a stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stall/flush for load-use, taken branch, multi-cycle MDU and data-memory waits.
// Zero latency: outputs are combinational from FSM/countdown and current inputs; a memory wait freezes everything.
module hazard_ctrl #(
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [4:0]       i_id_rs1,
   input  logic [4:0]       i_id_rs2,
   input  logic             i_id_uses_rs1,
   input  logic             i_id_uses_rs2,
   input  logic             i_ex_valid,
   input  logic             i_ex_mem_read,
   input  logic [4:0]       i_ex_rd,
   input  logic             i_ex_mdu_start,
   input  logic             i_ex_branch_taken,
   input  logic             i_mem_req,
   input  logic             i_mem_ready,
   output logic             o_pc_stall,
   output logic             o_if_id_stall,
   output logic             o_if_id_flush,
   output logic             o_id_ex_stall,
   output logic             o_id_ex_flush,
   output logic             o_ex_mem_stall,
   output logic             o_ex_mem_flush,
   output logic             o_mdu_busy,
   output logic [CNT_W-1:0] o_stall_cycles
);

   typedef enum logic {ST_RUN, ST_MDU_BUSY} state_t;

   localparam logic [3:0]       MDU_INIT = 4'(MDU_LAT - 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [3:0]       r_mdu_cnt;
   logic [CNT_W-1:0] r_stall_cycles;

   logic w_mem_wait;
   logic w_in_run;
   logic w_mdu_stall;
   logic w_branch;
   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_load_use;
   logic w_pc_stall;

   assign w_mem_wait  = i_mem_req & ~i_mem_ready;
   assign w_in_run    = (r_state == ST_RUN);

   // The final MDU_BUSY cycle (count 0) releases the pipeline so the result can advance.
   assign w_mdu_stall = ~w_mem_wait &
                        ((w_in_run & i_ex_mdu_start) |
                         (~w_in_run & (r_mdu_cnt != 4'd0)));

   assign w_branch    = ~w_mem_wait & w_in_run & ~i_ex_mdu_start & i_ex_branch_taken;

   assign w_rs1_hit   = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
   assign w_rs2_hit   = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
   assign w_load_use  = ~w_mem_wait & w_in_run & ~i_ex_mdu_start & ~i_ex_branch_taken &
                        i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0) &
                        (w_rs1_hit | w_rs2_hit);

   assign w_pc_stall  = w_mem_wait | w_mdu_stall | w_load_use;

   assign o_pc_stall     = ~i_reset & w_pc_stall;
   assign o_if_id_stall  = ~i_reset & w_pc_stall;
   assign o_if_id_flush  = ~i_reset & w_branch;
   assign o_id_ex_stall  = ~i_reset & (w_mem_wait | w_mdu_stall);
   assign o_id_ex_flush  = ~i_reset & (w_branch | w_load_use);
   assign o_ex_mem_stall = ~i_reset & w_mem_wait;
   assign o_ex_mem_flush = ~i_reset & w_mdu_stall;
   assign o_mdu_busy     = ~i_reset & ~w_in_run;
   assign o_stall_cycles = i_reset ? '0 : r_stall_cycles;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= ST_RUN;
         r_mdu_cnt      <= 4'd0;
         r_stall_cycles <= '0;
      end else begin
         if (!w_mem_wait) begin
            case (r_state)
               ST_RUN: begin
                  if (i_ex_mdu_start) begin
                     r_state   <= ST_MDU_BUSY;
                     r_mdu_cnt <= MDU_INIT;
                  end
               end
               ST_MDU_BUSY: begin
                  if (r_mdu_cnt != 4'd0) begin
                     r_mdu_cnt <= r_mdu_cnt - 4'd1;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
               default: r_state <= ST_RUN;
            endcase
         end
         if (w_pc_stall && (r_stall_cycles != CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + CNT_ONE;
         end
      end
   end

   a_if_id_excl: assert property (@(posedge i_clk) !(o_if_id_stall && o_if_id_flush));
   a_id_ex_excl: assert property (@(posedge i_clk) !(o_id_ex_stall && o_id_ex_flush));
   a_ex_mem_excl: assert property (@(posedge i_clk) !(o_ex_mem_stall && o_ex_mem_flush));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios plus randomized traffic vs a cycle-level reference model.
module tb_hazard_ctrl;

   localparam int MDU_LAT = 4;
   localparam int SAT_W   = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_uses_rs1 = 0, id_uses_rs2 = 0, ex_valid = 0, ex_mem_read = 0;
   logic       ex_mdu_start = 0, ex_branch_taken = 0, mem_req = 0, mem_ready = 0;

   logic [7:0]       act_flags, act_flags_s;
   logic [15:0]      act_cnt;
   logic [SAT_W-1:0] act_cnt_s;

   // flags order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mdu_busy
   hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(16)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
      .i_ex_valid(ex_valid), .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd),
      .i_ex_mdu_start(ex_mdu_start), .i_ex_branch_taken(ex_branch_taken),
      .i_mem_req(mem_req), .i_mem_ready(mem_ready),
      .o_pc_stall(act_flags[7]), .o_if_id_stall(act_flags[6]), .o_if_id_flush(act_flags[5]),
      .o_id_ex_stall(act_flags[4]), .o_id_ex_flush(act_flags[3]),
      .o_ex_mem_stall(act_flags[2]), .o_ex_mem_flush(act_flags[1]),
      .o_mdu_busy(act_flags[0]), .o_stall_cycles(act_cnt)
   );

   // Narrow counter instance exercises saturation within a short run.
   hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(SAT_W)) dut_s (
      .i_clk(clk), .i_reset(reset),
      .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2),
      .i_ex_valid(ex_valid), .i_ex_mem_read(ex_mem_read), .i_ex_rd(ex_rd),
      .i_ex_mdu_start(ex_mdu_start), .i_ex_branch_taken(ex_branch_taken),
      .i_mem_req(mem_req), .i_mem_ready(mem_ready),
      .o_pc_stall(act_flags_s[7]), .o_if_id_stall(act_flags_s[6]), .o_if_id_flush(act_flags_s[5]),
      .o_id_ex_stall(act_flags_s[4]), .o_id_ex_flush(act_flags_s[3]),
      .o_ex_mem_stall(act_flags_s[2]), .o_ex_mem_flush(act_flags_s[1]),
      .o_mdu_busy(act_flags_s[0]), .o_stall_cycles(act_cnt_s)
   );

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1, rs2;
      logic       u1, u2, ev, mr;
      logic [4:0] rd;
      logic       ms, bt, mq, mrdy;
   } stim_t;

   typedef struct {
      int               id;
      logic [7:0]       flags;
      logic [15:0]      cnt;
      logic [SAT_W-1:0] cnt_s;
   } exp_t;

   exp_t sb_q[$];

   // Model state: m_phase = -1 when no mul/div is in flight, else how many
   // non-waiting cycles of the op have elapsed (1 .. MDU_LAT-1).
   int m_phase  = -1;
   int m_total  = 0;
   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   function automatic exp_t model(stim_t s);
      exp_t e;
      bit mw, mdu, br, lu, idle;
      e.id = cyc; e.flags = '0; e.cnt = '0; e.cnt_s = '0;
      if (s.rst) return e;
      idle = (m_phase < 0);
      mw   = s.mq && !s.mrdy;
      mdu  = !mw && ((idle && s.ms) || (m_phase >= 1 && m_phase < MDU_LAT - 1));
      br   = !mw && idle && !s.ms && s.bt;
      lu   = !mw && idle && !s.ms && !s.bt && s.ev && s.mr && (s.rd != 0) &&
             ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      e.flags = {mw | mdu | lu, mw | mdu | lu, br, mw | mdu, br | lu, mw, mdu, !idle};
      e.cnt   = 16'((m_total > 65535) ? 65535 : m_total);
      e.cnt_s = SAT_W'((m_total > 7) ? 7 : m_total);
      return e;
   endfunction

   task automatic advance(stim_t s, exp_t e);
      if (s.rst) begin
         m_phase = -1;
         m_total = 0;
      end else begin
         if (!(s.mq && !s.mrdy)) begin
            if (m_phase < 0) begin
               if (s.ms) m_phase = 1;
            end else if (m_phase == MDU_LAT - 1) begin
               m_phase = -1;
            end else begin
               m_phase++;
            end
         end
         if (e.flags[7]) m_total++;
      end
   endtask

   task automatic step(stim_t s);
      exp_t e;
      @(posedge clk); #1;
      reset = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2;
      id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_valid = s.ev; ex_mem_read = s.mr;
      ex_rd = s.rd; ex_mdu_start = s.ms; ex_branch_taken = s.bt;
      mem_req = s.mq; mem_ready = s.mrdy;
      e = model(s);
      sb_q.push_back(e);
      advance(s, e);
      cyc++;
   endtask

   function automatic stim_t nop();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst  = ($urandom_range(0, 199) == 0);
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.rd   = 5'($urandom_range(0, 3));
      s.u1   = 1'($urandom);
      s.u2   = 1'($urandom);
      s.ev   = ($urandom_range(0, 3) != 0);
      s.mr   = 1'($urandom);
      s.bt   = ($urandom_range(0, 5) == 0);
      s.mq   = ($urandom_range(0, 2) == 0);
      s.mrdy = 1'($urandom);
      s.ms   = (m_phase >= 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      return s;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (act_flags !== e.flags) begin
               failures++;
               $display("FAIL flags cyc=%0d got=%b exp=%b", e.id, act_flags, e.flags);
            end
            checks++;
            if (act_cnt !== e.cnt) begin
               failures++;
               $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d", e.id, act_cnt, e.cnt);
            end
            checks++;
            if (act_flags_s !== e.flags) begin
               failures++;
               $display("FAIL flags_sat_inst cyc=%0d got=%b exp=%b", e.id, act_flags_s, e.flags);
            end
            checks++;
            if (act_cnt_s !== e.cnt_s) begin
               failures++;
               $display("FAIL stall_cycles_sat cyc=%0d got=%0d exp=%0d", e.id, act_cnt_s, e.cnt_s);
            end
         end
      end
   end

   initial begin : stimulus
      stim_t s;
      s = nop(); s.rst = 1; step(s); step(s);

      // load-use hit, then bubble, then ex_rd=0 and unused-rs1 variants
      s = nop(); s.ev = 1; s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; step(s);
      s.ev = 0; step(s);
      s.ev = 1; s.rd = 0; s.rs1 = 0; step(s);
      s.rd = 5; s.rs1 = 5; s.u1 = 0; step(s);
      step(nop());

      // MDU op with start held through its final cycle
      s = nop(); s.ms = 1;
      for (int i = 0; i < MDU_LAT; i++) step(s);
      step(nop());

      // branch together with a load-use match: flush only
      s = nop(); s.bt = 1; s.ev = 1; s.mr = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1; step(s);
      step(nop());

      // two memory-wait cycles with a pending branch, then the access completes
      s = nop(); s.mq = 1; s.mrdy = 0; s.bt = 1; step(s); step(s);
      s.mrdy = 1; step(s);
      step(nop());

      // MDU with a 2-cycle memory wait starting in its second cycle
      s = nop(); s.ms = 1; step(s);
      s.mq = 1; step(s); step(s);
      s.mq = 0; step(s); step(s); step(s);
      step(nop());

      // reset in the second cycle of an MDU op
      s = nop(); s.ms = 1; step(s);
      s.rst = 1; step(s);
      step(nop()); step(nop());

      // a long stall run saturates the narrow counter
      s = nop(); s.mq = 1;
      for (int i = 0; i < 10; i++) step(s);
      step(nop());

      for (int i = 0; i < 4000; i++) step(rand_stim());
      step(nop());

      @(negedge clk); #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
